// File: rtl/hkg_multi_keygen.sv
// hkg_multi_keygen: per-channel log-style keys mixed with a saturating fixed-point Lorenz stepper, streamed over valid/ready
module hkg_multi_keygen #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int NUM_KEYS = 2,
  parameter int WARMUP   = 64,
  parameter int DT_SHIFT = 8,
  parameter int BETA_Q   = (8 << FRAC) / 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NUM_KEYS*WIDTH-1:0]     r_vec,
  input  logic [WIDTH-1:0]              p,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [WIDTH-1:0]              key_out,
  output logic [$clog2(NUM_KEYS):0]     key_idx,
  output logic                          key_last,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_KEYS) + 1;
  localparam int NK = 1 << IW;
  localparam int L  = 2 * WIDTH + 2;
  localparam logic signed [WIDTH-1:0] W_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] C_ONE  = WIDTH'(1) << FRAC;
  localparam logic signed [WIDTH-1:0] C_28   = WIDTH'(28) << FRAC;
  localparam logic signed [WIDTH-1:0] C_BETA = WIDTH'(BETA_Q);

  typedef enum logic [1:0] {IDLE, SEED, WARM, EMIT} state_t;

  // Arithmetic is carried at 2*WIDTH+2 bits so full products and sums never wrap before clamping
  function automatic logic signed [L-1:0] sx(input logic signed [WIDTH-1:0] v);
    return {{(L-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [L-1:0] v);
    return (v > sx(W_MAX)) ? W_MAX : (v < sx(W_MIN)) ? W_MIN : v[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int s);
    logic [2*WIDTH-1:0] t;
    t = {v, v} << (s % WIDTH);
    return t[2*WIDTH-1:WIDTH];
  endfunction

  function automatic int msb(input logic [WIDTH-1:0] v);
    int m;
    m = 0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) m = i;
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] keyf(input logic [WIDTH-1:0] lk, x, y, input logic [IW-1:0] k);
    return lk ^ x ^ rotl(y, int'(k));
  endfunction

  state_t                   r_st;
  logic signed [WIDTH-1:0]  r_x, r_y, r_z;
  logic [7:0]               r_p8;
  logic [15:0]              r_cnt;
  logic [WIDTH-1:0]         r_lk [NK];
  logic [WIDTH-1:0]         w_lk [NK];
  logic [IW-1:0]            w_kn;
  logic signed [WIDTH-1:0]  w_v, w_dx, w_a, w_dy, w_dz, w_nx, w_ny, w_nz, w_sx;

  // Channel log-keys from the live inputs; slots beyond NUM_KEYS pad the array to a power of two
  for (genvar i = 0; i < NK; i++) begin : g_lk
    if (i < NUM_KEYS) begin : g_on
      assign w_lk[i] = rotl(r_vec[i*WIDTH +: WIDTH] ^ p, msb(r_vec[i*WIDTH +: WIDTH]));
    end else begin : g_off
      assign w_lk[i] = '0;
    end
  end

  // One Euler step of the Lorenz system, every intermediate clamped to the signed WIDTH range
  always_comb begin
    w_v  = sat(sx(r_y) - sx(r_x));
    w_dx = sat((sx(w_v) <<< 3) + (sx(w_v) <<< 1));
    w_a  = sat(sx(C_28) - sx(r_z));
    w_dy = sat(((sx(r_x) * sx(w_a)) >>> FRAC) - sx(r_y));
    w_dz = sat(((sx(r_x) * sx(r_y)) >>> FRAC) - ((sx(C_BETA) * sx(r_z)) >>> FRAC));
    w_nx = sat(sx(r_x) + (sx(w_dx) >>> DT_SHIFT));
    w_ny = sat(sx(r_y) + (sx(w_dy) >>> DT_SHIFT));
    w_nz = sat(sx(r_z) + (sx(w_dz) >>> DT_SHIFT));
    w_sx = C_ONE + (WIDTH'(r_p8) << (FRAC - 8));
    w_kn = key_idx + IW'(1);
  end

  // Request FSM; key_out is precomputed from the next chaos state so every output is a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st      <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      key_out   <= '0;
      key_idx   <= '0;
      key_last  <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_p8      <= '0;
      r_cnt     <= '0;
      r_lk      <= '{default: '0};
    end else begin
      case (r_st)
        IDLE: if (req_valid) begin
          r_lk      <= w_lk;
          r_p8      <= p[7:0];
          r_st      <= SEED;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
        SEED: begin
          r_x   <= w_sx;
          r_y   <= C_ONE;
          r_z   <= C_ONE;
          r_cnt <= '0;
          if (WARMUP == 0) begin
            r_st      <= EMIT;
            key_valid <= 1'b1;
            key_out   <= keyf(r_lk[0], w_sx, C_ONE, '0);
            key_idx   <= '0;
            key_last  <= (NUM_KEYS == 1);
          end else begin
            r_st <= WARM;
          end
        end
        WARM: begin
          r_x <= w_nx;
          r_y <= w_ny;
          r_z <= w_nz;
          if (r_cnt == 16'(WARMUP - 1)) begin
            r_st      <= EMIT;
            key_valid <= 1'b1;
            key_out   <= keyf(r_lk[0], w_nx, w_ny, '0);
            key_idx   <= '0;
            key_last  <= (NUM_KEYS == 1);
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        EMIT: if (key_ready) begin
          r_x <= w_nx;
          r_y <= w_ny;
          r_z <= w_nz;
          if (key_last) begin
            r_st      <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            key_out   <= '0;
            key_idx   <= '0;
            key_last  <= 1'b0;
          end else begin
            key_idx  <= w_kn;
            key_out  <= keyf(r_lk[w_kn], w_nx, w_ny, w_kn);
            key_last <= (w_kn == IW'(NUM_KEYS - 1));
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hkg_multi_keygen.sv
// tb_hkg_multi_keygen: directed checks of the multi-key generator against a 64-bit saturating Lorenz model
module tb_hkg_multi_keygen;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_valid1 = 1'b0, key_ready = 1'b1;
  logic [63:0] r_vec = '0;
  logic [31:0] p = '0;
  logic        req_ready, key_valid, key_last, busy;
  logic        req_ready1, key_valid1, key_last1, busy1;
  logic [31:0] key_out, key_out1;
  logic [1:0]  key_idx, key_idx1;
  int          checks = 0, errors = 0;
  longint      mx, my, mz;
  logic [31:0] ml [2];

  hkg_multi_keygen #(.WIDTH(32), .FRAC(16), .NUM_KEYS(2), .WARMUP(4), .DT_SHIFT(8)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .r_vec(r_vec), .p(p),
    .key_valid(key_valid), .key_ready(key_ready), .key_out(key_out), .key_idx(key_idx),
    .key_last(key_last), .busy(busy));

  hkg_multi_keygen #(.WIDTH(32), .FRAC(16), .NUM_KEYS(2), .WARMUP(2000), .DT_SHIFT(8)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1), .r_vec(r_vec), .p(p),
    .key_valid(key_valid1), .key_ready(key_ready), .key_out(key_out1), .key_idx(key_idx1),
    .key_last(key_last1), .busy(busy1));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint s32(input longint v);
    return (v > 64'sh7FFFFFFF) ? 64'sh7FFFFFFF : (v < -64'sh80000000) ? -64'sh80000000 : v;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    int t;
    t = s % 32;
    return (t == 0) ? v : (v << t) | (v >> (32 - t));
  endfunction

  function automatic logic [31:0] m_lk(input logic [31:0] r, input logic [31:0] pp);
    int m;
    m = 0;
    for (int i = 31; i >= 0; i--) if (r[i]) begin m = i; break; end
    return rl(r ^ pp, m);
  endfunction

  function automatic logic [31:0] mkey(input int k);
    return ml[k] ^ 32'(mx) ^ rl(32'(my), k);
  endfunction

  task automatic m_step;
    longint v, dx, a, dy, dz;
    v  = s32(my - mx);
    dx = s32(v * 10);
    a  = s32(28 * 65536 - mz);
    dy = s32(((mx * a) >>> 16) - my);
    dz = s32(((mx * my) >>> 16) - ((174762 * mz) >>> 16));
    mx = s32(mx + (dx >>> 8));
    my = s32(my + (dy >>> 8));
    mz = s32(mz + (dz >>> 8));
  endtask

  task automatic start(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] pp);
    r_vec = {r1, r0};
    p     = pp;
    ml[0] = m_lk(r0, pp);
    ml[1] = m_lk(r1, pp);
    mx    = 65536 + longint'(pp[7:0]) * 256;
    my    = 65536;
    mz    = 65536;
  endtask

  task automatic expect_key(input string tag, input int k, input logic last);
    chk({tag, "_valid"}, 32'(key_valid), 1);
    chk({tag, "_key"}, key_out, mkey(k));
    chk({tag, "_idx"}, 32'(key_idx), 32'(k));
    chk({tag, "_last"}, 32'(key_last), 32'(last));
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("idle_ready", 32'(req_ready), 1);
      chk("idle_valid", 32'(key_valid), 0);
      chk("idle_key", key_out, 0);
      chk("idle_busy", 32'(busy), 0);
      tick();
    end

    start(32'h0, 32'h0, 32'h0);
    repeat (4) m_step();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 6; c++) begin
      chk("t2_latency", 32'(key_valid), 0);
      chk("t2_busy", 32'(busy), 1);
      tick();
    end
    expect_key("t2_k0", 0, 1'b0);
    tick();
    m_step();
    expect_key("t2_k1", 1, 1'b1);
    tick();
    m_step();
    chk("t2_done_valid", 32'(key_valid), 0);
    chk("t2_done_ready", 32'(req_ready), 1);

    start(32'h0000_0100, 32'h8000_0003, 32'h0000_0001);
    repeat (4) m_step();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("t3_lk0", key_out ^ 32'(mx) ^ 32'(my), 32'h0001_0100);
    tick();
    m_step();
    chk("t3_lk1", key_out ^ 32'(mx) ^ rl(32'(my), 1), 32'h4000_0001);
    chk("t3_last", 32'(key_last), 1);
    tick();
    m_step();

    start(32'hDEAD_BEEF, 32'h0000_0001, 32'h1234_5678);
    repeat (4) m_step();
    key_ready = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    repeat (5) begin
      expect_key("t4_stall0", 0, 1'b0);
      tick();
    end
    key_ready = 1'b1;
    expect_key("t4_k0", 0, 1'b0);
    tick();
    m_step();
    key_ready = 1'b0;
    repeat (3) begin
      expect_key("t4_stall1", 1, 1'b1);
      tick();
    end
    key_ready = 1'b1;
    expect_key("t4_k1", 1, 1'b1);
    tick();
    m_step();
    chk("t4_done", 32'(key_valid), 0);

    start(32'h0F0F_0F0F, 32'h0000_0007, 32'hA5A5_A5A5);
    repeat (4) m_step();
    req_valid = 1'b1;
    tick();
    r_vec = ~r_vec;
    p = ~p;
    repeat (5) tick();
    chk("t5_ready_busy", 32'(req_ready), 0);
    expect_key("t5_k0", 0, 1'b0);
    tick();
    m_step();
    expect_key("t5_k1", 1, 1'b1);
    req_valid = 1'b0;
    tick();
    for (int c = 0; c < 8; c++) begin
      chk("t5_single_valid", 32'(key_valid), 0);
      chk("t5_single_ready", 32'(req_ready), 1);
      tick();
    end
    start(32'h0000_0055, 32'h0000_0066, 32'h0000_0077);
    repeat (4) m_step();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    expect_key("t5r_k0", 0, 1'b0);
    tick();
    m_step();
    expect_key("t5r_k1", 1, 1'b1);
    reset = 1'b1;
    tick();
    chk("t5r_valid", 32'(key_valid), 0);
    chk("t5r_ready", 32'(req_ready), 1);
    chk("t5r_key", key_out, 0);
    chk("t5r_busy", 32'(busy), 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("t5r_quiet", 32'(key_valid), 0);
      tick();
    end

    start(32'h1357_9BDF, 32'h2468_ACE0, 32'h0000_00FF);
    repeat (2000) m_step();
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    repeat (2000) tick();
    chk("t6_latency", 32'(key_valid1), 0);
    tick();
    chk("t6_k0_valid", 32'(key_valid1), 1);
    chk("t6_k0_key", key_out1, mkey(0));
    chk("t6_k0_idx", 32'(key_idx1), 0);
    tick();
    m_step();
    chk("t6_k1_key", key_out1, mkey(1));
    chk("t6_k1_idx", 32'(key_idx1), 1);
    chk("t6_k1_last", 32'(key_last1), 1);
    tick();
    chk("t6_done", 32'(key_valid1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
